// File: rtl/hpm_counter_file.sv
// Machine HPM counter file: NUM_CNT event counters mhpmcounter3.., mhpmevent
// selectors with sticky overflow, and the owned slice of mcountinhibit.

module hpm_counter_lane #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 evt,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic                 wr_evt,
  input  logic                 wr_inh,
  input  logic [31:0]          wdata,
  input  logic                 inh_in,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [7:0]           sel,
  output logic                 of,
  output logic                 ofie,
  output logic                 inh
);
  logic inc, wrap, cnt_wr;
  logic unused_wdata;

  assign inc          = !inh && evt;
  assign wrap         = inc && (&cnt);
  assign cnt_wr       = wr_lo || wr_hi;
  assign unused_wdata = ^wdata[29:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      sel  <= '0;
      of   <= 1'b0;
      ofie <= 1'b0;
      inh  <= 1'b1;
    end else begin
      // A software write to either half drops this cycle's increment and its overflow.
      if (wr_lo) cnt[31:0] <= wdata;
      if (wr_hi) cnt[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
      if (!cnt_wr && inc) cnt <= cnt + CNT_WIDTH'(1);
      if (wr_evt) begin
        sel  <= wdata[7:0];
        ofie <= wdata[30];
        of   <= wdata[31] | (wrap & !cnt_wr);
      end else if (wrap && !cnt_wr) begin
        of <= 1'b1;
      end
      if (wr_inh) inh <= inh_in;
    end
  end
endmodule

module hpm_counter_file #(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic               csr_wena,
  input  logic [31:0]        csr_wdata,
  input  logic               csr_rena,
  output logic [31:0]        csr_rdata,
  output logic               csr_hit,
  input  logic [NUM_EVT-1:0] events,
  output logic               irq_ovf
);
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_CNT-1:0][7:0]           sel;
  logic [NUM_CNT-1:0]                of, ofie, inh;

  logic [4:0]   idx;
  logic         in_win, is_lo, is_hi, is_evt, is_inh;
  logic [255:0] ev_pad;

  // Slot 0 is a constant 0 so SEL=0 and SEL>NUM_EVT both select a zero bit.
  assign ev_pad = 256'({events, 1'b0});

  assign idx     = csr_addr[4:0] - 5'd3;
  assign in_win  = csr_addr[4:0] >= 5'd3;
  assign is_lo   = (csr_addr[11:5] == 7'h58) && in_win;
  assign is_hi   = (csr_addr[11:5] == 7'h5C) && in_win;
  assign is_evt  = (csr_addr[11:5] == 7'h19) && in_win;
  assign is_inh  = csr_addr == 12'h320;
  assign csr_hit = is_lo | is_hi | is_evt | is_inh;
  assign irq_ovf = |(of & ofie);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_lane
    hpm_counter_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .evt    (ev_pad[sel[i]]),
      .wr_lo  (csr_wena && is_lo  && idx == 5'(i)),
      .wr_hi  (csr_wena && is_hi  && idx == 5'(i)),
      .wr_evt (csr_wena && is_evt && idx == 5'(i)),
      .wr_inh (csr_wena && is_inh),
      .wdata  (csr_wdata),
      .inh_in (csr_wdata[3+i]),
      .cnt    (cnt[i]),
      .sel    (sel[i]),
      .of     (of[i]),
      .ofie   (ofie[i]),
      .inh    (inh[i])
    );
  end

  // Indices past NUM_CNT match no lane and read as zero.
  always_comb begin
    csr_rdata = '0;
    if (csr_rena) begin
      if (is_inh) csr_rdata = 32'({inh, 3'b000});
      for (int i = 0; i < NUM_CNT; i++) begin
        if (idx == 5'(i)) begin
          if (is_lo)  csr_rdata = cnt[i][31:0];
          if (is_hi)  csr_rdata = 32'(cnt[i][CNT_WIDTH-1:32]);
          if (is_evt) csr_rdata = {of[i], ofie[i], 22'd0, sel[i]};
        end
      end
    end
  end
endmodule

// File: tb/tb_hpm_counter_file.sv
// Table-driven bench for hpm_counter_file: one record per cycle, expectations
// queued at drive time and popped at the following negedge.

module tb_hpm_counter_file;
  localparam int NUM_CNT = 2, CNT_WIDTH = 40, NUM_EVT = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [11:0]        csr_addr;
  logic               csr_wena, csr_rena;
  logic [31:0]        csr_wdata, csr_rdata;
  logic               csr_hit, irq_ovf;
  logic [NUM_EVT-1:0] events;

  always #5 clk = ~clk;

  hpm_counter_file #(.NUM_CNT(NUM_CNT), .CNT_WIDTH(CNT_WIDTH), .NUM_EVT(NUM_EVT)) dut (
    .clk       (clk),
    .reset     (reset),
    .csr_addr  (csr_addr),
    .csr_wena  (csr_wena),
    .csr_wdata (csr_wdata),
    .csr_rena  (csr_rena),
    .csr_rdata (csr_rdata),
    .csr_hit   (csr_hit),
    .events    (events),
    .irq_ovf   (irq_ovf)
  );

  typedef struct {
    int                 id;
    logic               rst, we, re;
    logic [11:0]        addr;
    logic [31:0]        wd;
    logic [NUM_EVT-1:0] ev;
    logic               chk, hit;
    logic [31:0]        rd;
    logic               irq;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0, bad = 0, row = 0;

  task automatic add(input logic rst, input logic we, input logic re, input logic [11:0] a,
                     input logic [31:0] wd, input logic [NUM_EVT-1:0] ev, input logic chk,
                     input logic hit, input logic [31:0] rd, input logic irq);
    vec_t v;
    v = '{id: 0, rst: rst, we: we, re: re, addr: a, wd: wd, ev: ev,
          chk: chk, hit: hit, rd: rd, irq: irq};
    tbl.push_back(v);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic irq,
                    input logic [NUM_EVT-1:0] ev);
    add(1'b0, 1'b0, 1'b1, a, 32'd0, ev, 1'b1, 1'b1, d, irq);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [NUM_EVT-1:0] ev);
    add(1'b0, 1'b1, 1'b0, a, d, ev, 1'b0, 1'b1, 32'd0, 1'b0);
  endtask

  task automatic idle(input logic [NUM_EVT-1:0] ev, input int n);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, ev, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    reset     = v.rst;
    csr_wena  = v.we;
    csr_rena  = v.re;
    csr_addr  = v.addr;
    csr_wdata = v.wd;
    events    = v.ev;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) begin
      total += 3;
      if (csr_hit !== e.hit) begin
        bad++;
        $display("FAIL hit row %0d addr=%h: got %b want %b", e.id, e.addr, csr_hit, e.hit);
      end
      if (csr_rdata !== e.rd) begin
        bad++;
        $display("FAIL rdata row %0d addr=%h: got %h want %h", e.id, e.addr, csr_rdata, e.rd);
      end
      if (irq_ovf !== e.irq) begin
        bad++;
        $display("FAIL irq row %0d: got %b want %b", e.id, irq_ovf, e.irq);
      end
    end
  endtask

  task automatic run_tbl();
    vec_t v;
    while (tbl.size() > 0) begin
      v = tbl.pop_front();
      v.id = row++;
      step(v);
    end
  endtask

  initial begin
    reset = 1'b1; csr_wena = 1'b0; csr_rena = 1'b0;
    csr_addr = '0; csr_wdata = '0; events = '0;

    // reset and reset values
    add(1'b1, 1'b0, 1'b0, 12'h000, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 12'h000, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    rd(12'h320, 32'h18, 1'b0, 4'h0);
    rd(12'hB03, 32'h0, 1'b0, 4'h0);
    rd(12'h323, 32'h0, 1'b0, 4'h0);
    rd(12'hB04, 32'h0, 1'b0, 4'h0);

    // basic counting; inhibit change applies from the next cycle
    add(1'b0, 1'b1, 1'b0, 12'h323, 32'h1, 4'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    wr(12'h320, 32'h10, 4'h1);
    idle(4'h1, 10);
    rd(12'hB03, 32'd10, 1'b0, 4'h0);
    rd(12'hB83, 32'd0, 1'b0, 4'h0);
    wr(12'h320, 32'h18, 4'h1);
    idle(4'h1, 1);
    rd(12'hB03, 32'd11, 1'b0, 4'h1);
    rd(12'hB04, 32'd0, 1'b0, 4'h0);

    // overflow of the full 40-bit counter
    wr(12'hB03, 32'hFFFF_FFFF, 4'h0);
    wr(12'hB83, 32'hFFFF_FFFF, 4'h0);
    rd(12'hB83, 32'hFF, 1'b0, 4'h0);
    wr(12'h323, 32'h4000_0001, 4'h0);
    wr(12'h320, 32'h10, 4'h0);
    rd(12'h323, 32'h4000_0001, 1'b0, 4'h1);
    rd(12'h323, 32'hC000_0001, 1'b1, 4'h0);
    rd(12'hB03, 32'h0, 1'b1, 4'h0);
    rd(12'hB83, 32'h0, 1'b1, 4'h0);
    add(1'b0, 1'b1, 1'b0, 12'h323, 32'h4000_0001, 4'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    rd(12'h323, 32'h4000_0001, 1'b0, 4'h0);

    // write beats increment, halves independent
    wr(12'hB83, 32'h5A, 4'h0);
    idle(4'h1, 1);
    wr(12'hB03, 32'h100, 4'h1);
    rd(12'hB03, 32'h100, 1'b0, 4'h1);
    rd(12'hB83, 32'h5A, 1'b0, 4'h0);
    wr(12'hB83, 32'h12, 4'h1);
    rd(12'hB03, 32'h101, 1'b0, 4'h0);
    rd(12'hB83, 32'h12, 1'b0, 4'h0);

    // unimplemented / foreign addresses, out-of-range SEL
    rd(12'hB05, 32'h0, 1'b0, 4'h0);
    wr(12'hB05, 32'hDEAD, 4'h0);
    rd(12'hB05, 32'h0, 1'b0, 4'h0);
    rd(12'hB9F, 32'h0, 1'b0, 4'h0);
    rd(12'h33F, 32'h0, 1'b0, 4'h0);
    add(1'b0, 1'b0, 1'b1, 12'hB20, 32'd0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 12'h321, 32'd0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    wr(12'h324, 32'h3FFF_FF05, 4'h0);
    wr(12'h320, 32'h0, 4'h0);
    idle(4'hF, 3);
    rd(12'hB04, 32'h0, 1'b0, 4'h0);
    rd(12'h324, 32'h5, 1'b0, 4'h0);
    run_tbl();

    // reset while counting with a pending interrupt
    wr(12'h323, 32'hC000_0001, 4'h0);
    wr(12'hB03, 32'h1234, 4'h0);
    rd(12'hB03, 32'h1234, 1'b1, 4'h1);
    add(1'b1, 1'b0, 1'b0, 12'h000, 32'd0, 4'h1, 1'b0, 1'b0, 32'd0, 1'b0);
    rd(12'hB03, 32'h0, 1'b0, 4'h1);
    rd(12'h320, 32'h18, 1'b0, 4'h0);
    rd(12'h323, 32'h0, 1'b0, 4'h0);
    rd(12'hB83, 32'h0, 1'b0, 4'h0);
    run_tbl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hpm_counter_file.md
Name: hpm_counter_file

Overview:
- Parametrised machine-level hardware performance monitor (HPM) block, generalising the fixed mcycle/minstret pair to NUM_CNT event counters mhpmcounter3..(3+NUM_CNT-1).
- Each counter has a selectable event source, a per-counter inhibit, a sticky overflow flag and an optional overflow interrupt.
- Sits beside csr_file on the same CSR access bus. csr_file ORs in csr_rdata when csr_hit is set, and routes irq_ovf into its custom interrupt lines.

Parameters:
- NUM_CNT, 8, number of implemented counters (1..29).
- CNT_WIDTH, 64, implemented counter width in bits (33..64).
- NUM_EVT, 16, number of event inputs (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_addr  in  12  CSR address
- csr_wena  in  1  CSR write strobe
- csr_wdata  in  32  final write value (set/clear already resolved upstream)
- csr_rena  in  1  CSR read strobe
- csr_rdata  out  32  read data; 0 when no hit or csr_rena=0
- csr_hit  out  1  csr_addr decodes to a CSR owned by this block
- events  in  NUM_EVT  per-cycle event pulses; level-sampled every cycle
- irq_ovf  out  1  overflow interrupt request

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - All counters 0.
  - All mhpmevent registers 0 (sel=0, OF=0, OFIE=0).
  - All inhibit bits 1.
  - irq_ovf=0; csr_rdata=0.
- Address map, counter i = 0..NUM_CNT-1:
  - mhpmcounter: 0xB03+i, bits [31:0].
  - mhpmcounterh: 0xB83+i, bits [CNT_WIDTH-1:32]; unimplemented upper bits read 0 and ignore writes.
  - mhpmevent: 0x323+i.
  - mcountinhibit at 0x320: this block owns bits [3+NUM_CNT-1:3] only. All other bits read 0 here and are ignored on write.
- Unimplemented HPM addresses (0xB03..0xB1F, 0xB83..0xB9F, 0x323..0x33F beyond NUM_CNT): csr_hit=1, read 0, writes ignored (WARL zero).
  - Any other address: csr_hit=0.
- mhpmevent fields:
  - [31] OF: sticky overflow flag.
  - [30] OFIE: overflow interrupt enable.
  - [7:0] SEL: 0 means never count; k in 1..NUM_EVT counts events[k-1]; k > NUM_EVT never counts. SEL is still stored as written.
  - All other bits read 0.
- Reads: combinational. csr_rdata is valid in the same cycle as csr_rena and reflects register state before any write on that edge. csr_hit does not depend on csr_rena.
- Increment:
  - Each cycle, counter i increments by 1 iff inhibit[i]=0, SEL is valid, and the selected event bit is 1.
  - Arithmetic is modulo 2^CNT_WIDTH.
- Overflow:
  - An increment from all-ones wraps the counter to 0 and sets OF on the same edge.
  - OF stays set until software writes mhpmevent with bit31=0.
- Simultaneous CSR write and increment on the same counter:
  - A write to mhpmcounter or mhpmcounterh wins; that cycle's increment is dropped, including any overflow.
  - A write to the lo half leaves the hi half unchanged, and vice versa.
- Simultaneous mhpmevent write and overflow of the same counter:
  - SEL and OFIE take the written value.
  - OF <= wdata[31] | overflow (hardware set wins).
- mcountinhibit write takes effect from the next cycle; the increment on the write edge uses the old inhibit value.
- irq_ovf = OR over i of (OF[i] & OFIE[i]), decoded from registers. It rises the cycle after the wrapping edge; there is no combinational path from events.
- Reset asserted mid-count: all state returns to reset values on that edge, and no increment is applied.
- Writes are ignored when csr_wena=0. csr_rena has no side effects.

Test Plan:
1. After reset: read 0x320 -> bits[10:3]=0xFF. Read 0xB03 and 0x323 -> 0. irq_ovf=0.
2. Write 0x323=0x00000001, clear inhibit bit 3, drive events[0]=1 for 10 cycles -> 0xB03 reads 10, 0xB83 reads 0. Same with inhibit bit 3 set -> count frozen.
3. Overflow:
   - Setup: write 0xB03=0xFFFFFFFF, 0xB83=0xFFFFFFFF, 0x323=0x40000001; uninhibit; one events[0] pulse.
   - Required: counter reads 0; 0x323 reads 0xC0000001; irq_ovf=1 one cycle after the edge.
   - Then write 0x323=0x40000001 -> irq_ovf=0 next cycle.
4. With events[0] held high, write 0xB03=0x100 -> reads 0x100 next cycle, not 0x101. Hi half unchanged.
5. NUM_CNT=2: read/write 0xB05 -> csr_hit=1, read 0, write ignored. 0xB20 -> csr_hit=0. SEL=NUM_EVT+1 -> never counts.
6. Assert reset while counting at value 0x1234 -> next cycle counter 0, inhibit bits all 1, irq_ovf=0.
